// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detectors.
// The mask helper is sized for the widest detector; callers narrow the result.
package seq_det_pkg;

    localparam int MASK_W = 64;

    localparam logic [MASK_W-1:0] DEF_PATTERN_C = 64'h0000_0000_0000_0009;
    localparam int                DEF_LEN_C     = 4;
    localparam bit                DEF_OVERLAP_C = 1'b0;

    // Width needed to hold any length 0..max_len.
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // One bit set for every pattern position below len.
    function automatic logic [MASK_W-1:0] len_mask(input int len);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_W; i++) begin
            if (i < len) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_detector_prog_if.sv
// Configuration, serial stream and result signals of one pattern detector.
interface seq_detector_prog_if
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = len_width(MAX_LEN);

    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               in_valid;
    logic               inbit;
    logic               count_clr;
    logic               detect;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;

    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        output in_valid, inbit, count_clr,
        input  detect, match_count, cfg_err
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        input  in_valid, inbit, count_clr,
        output detect, match_count, cfg_err
    );

endinterface

// File: rtl/seq_match_cmp.sv
// Combinational masked comparator: hit when enough history is present and the
// newest len bits equal the low len bits of the pattern.
module seq_match_cmp
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    localparam int LEN_W  = len_width(MAX_LEN)
) (
    input  logic [MAX_LEN-1:0] hist_next,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic [LEN_W-1:0]   fill_next,
    output logic               hit
);
    logic [MAX_LEN-1:0] mask;
    logic [MAX_LEN-1:0] diff;

    assign mask = MAX_LEN'(len_mask(int'(len)));

    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_diff
            assign diff[gi] = (hist_next[gi] ^ pattern[gi]) & mask[gi];
        end
    endgenerate

    assign hit = (fill_next >= len) && (diff == '0);

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector with a registered one-cycle
// detect pulse and a saturating match counter.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(DEF_PATTERN_C),
    parameter int                 DEF_LEN     = DEF_LEN_C,
    parameter bit                 DEF_OVERLAP = DEF_OVERLAP_C
) (
    input  logic               clk,
    input  logic               reset,
    seq_detector_prog_if.slave bus
);
    localparam int LEN_W = len_width(MAX_LEN);

    logic [MAX_LEN-1:0] hist_reg;
    logic [LEN_W-1:0]   fill_reg;
    logic [MAX_LEN-1:0] pattern_reg;
    logic [LEN_W-1:0]   len_reg;
    logic               overlap_reg;
    logic               detect_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               cfg_err_reg;

    logic [MAX_LEN-1:0] hist_next;
    logic [LEN_W-1:0]   fill_next;
    logic               hit;
    logic               match;
    logic               load_err;

    always_comb begin
        hist_next = {hist_reg[MAX_LEN-2:0], bus.inbit};
        fill_next = (fill_reg == LEN_W'(MAX_LEN)) ? fill_reg : fill_reg + LEN_W'(1);
        // A load in the same cycle as a valid bit discards that bit.
        match     = bus.in_valid && !bus.cfg_load && !cfg_err_reg && hit;
        load_err  = (bus.cfg_len == '0) || (bus.cfg_len > LEN_W'(MAX_LEN));
    end

    seq_match_cmp #(
        .MAX_LEN (MAX_LEN)
    ) u_cmp (
        .hist_next (hist_next),
        .pattern   (pattern_reg),
        .len       (len_reg),
        .fill_next (fill_next),
        .hit       (hit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_reg    <= '0;
            fill_reg    <= '0;
            pattern_reg <= DEF_PATTERN;
            len_reg     <= LEN_W'(DEF_LEN);
            overlap_reg <= DEF_OVERLAP;
            detect_reg  <= 1'b0;
            cfg_err_reg <= 1'b0;
        end else if (bus.cfg_load) begin
            hist_reg    <= '0;
            fill_reg    <= '0;
            pattern_reg <= bus.cfg_pattern;
            len_reg     <= bus.cfg_len;
            overlap_reg <= bus.cfg_overlap;
            detect_reg  <= 1'b0;
            cfg_err_reg <= load_err;
        end else begin
            detect_reg <= match;
            if (bus.in_valid) begin
                hist_reg <= hist_next;
                // Non-overlapping mode restarts from an empty history.
                fill_reg <= (match && !overlap_reg) ? '0 : fill_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.count_clr) begin
            count_reg <= '0;
        end else if (match && !(&count_reg)) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign bus.detect      = detect_reg;
    assign bus.match_count = count_reg;
    assign bus.cfg_err     = cfg_err_reg;

endmodule
